// File: rtl/led_pattern_ctrl.sv
// Registered NUM_LEDS-wide LED driver: static, blink, chase and bounce modes share one prescaler tick.
// Define LED_PWM_EN to add an 8-bit duty input that gates the pattern with a free-running PWM counter.
module led_pattern_ctrl #(
    parameter int NUM_LEDS = 8,
    parameter int TICK_DIV = 4,
    localparam int SEL_W = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
    input  logic                clk,
    input  logic                rst,
`ifdef LED_PWM_EN
    input  logic [7:0]          duty,
`endif
    input  logic                en,
    input  logic [1:0]          mode,
    input  logic [SEL_W-1:0]    sel,
    output logic [NUM_LEDS-1:0] leds,
    output logic                tick,
    output logic [SEL_W-1:0]    pos
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [SEL_W-1:0] POS_LAST = SEL_W'(NUM_LEDS - 1);

    typedef enum logic [1:0] {
        STATIC = 2'b00,
        BLINK  = 2'b01,
        CHASE  = 2'b10,
        BOUNCE = 2'b11
    } mode_t;

    typedef enum logic {UP = 1'b0, DOWN = 1'b1} dir_t;
    typedef enum logic {ON = 1'b0, OFF = 1'b1} phase_t;

    mode_t               mode_q;
    dir_t                dir, dir_n;
    phase_t              phase, phase_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [SEL_W-1:0]    pos_n;
    logic                tick_n;
    logic                mode_chg;
    logic                wrap;
    logic [NUM_LEDS-1:0] pattern;
    logic [NUM_LEDS-1:0] leds_n;

`ifdef LED_PWM_EN
    logic [7:0] pwm_cnt;
`endif

    function automatic logic [NUM_LEDS-1:0] onehot(input logic [SEL_W-1:0] idx);
        logic [NUM_LEDS-1:0] v;
        for (int i = 0; i < NUM_LEDS; i++) begin
            v[i] = (idx == SEL_W'(i));
        end
        return v;
    endfunction

    // A mode change restarts the timing state and suppresses any step that would coincide with it.
    always_comb begin
        cnt_n    = cnt;
        pos_n    = pos;
        dir_n    = dir;
        phase_n  = phase;
        tick_n   = 1'b0;
        pattern  = '0;
        leds_n   = '0;
        mode_chg = (mode != mode_q);
        wrap     = en && !mode_chg && (cnt == CNT_LAST);

        if (mode_chg) begin
            cnt_n   = '0;
            pos_n   = '0;
            dir_n   = UP;
            phase_n = ON;
        end else if (en) begin
            cnt_n  = wrap ? '0 : cnt + 1'b1;
            tick_n = wrap;
        end

        if (wrap) begin
            case (mode_q)
                BLINK:  phase_n = (phase == ON) ? OFF : ON;
                CHASE:  pos_n = (pos == POS_LAST) ? '0 : pos + 1'b1;
                BOUNCE: begin
                    if (NUM_LEDS > 1) begin
                        if (dir == UP) begin
                            pos_n = pos + 1'b1;
                            if (pos_n == POS_LAST) dir_n = DOWN;
                        end else begin
                            pos_n = pos - 1'b1;
                            if (pos_n == '0) dir_n = UP;
                        end
                    end
                end
                default: ;
            endcase
        end

        case (mode_t'(mode))
            STATIC:  pattern = onehot(sel);
            BLINK:   pattern = (phase_n == ON) ? onehot(sel) : '0;
            default: pattern = onehot(pos_n);
        endcase

`ifdef LED_PWM_EN
        leds_n = en ? (pattern & {NUM_LEDS{pwm_cnt < duty}}) : '0;
`else
        leds_n = en ? pattern : '0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            tick   <= 1'b0;
            pos    <= '0;
            dir    <= UP;
            phase  <= ON;
            mode_q <= STATIC;
            leds   <= '0;
        end else begin
            cnt    <= cnt_n;
            tick   <= tick_n;
            pos    <= pos_n;
            dir    <= dir_n;
            phase  <= phase_n;
            mode_q <= mode_t'(mode);
            leds   <= leds_n;
        end
    end

`ifdef LED_PWM_EN
    // PWM counter free-runs independently of the pattern timing so duty is exact over any 256 enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else if (en) begin
            pwm_cnt <= pwm_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl: 4-, 3- and 1-LED instances driven from shared inputs.
module tb_led_pattern_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [1:0] sel;

    logic [3:0] leds4;
    logic       tick4;
    logic [1:0] pos4;
    logic [2:0] leds3;
    logic       tick3;
    logic [1:0] pos3;
    logic [0:0] leds1;
    logic       tick1;
    logic [0:0] pos1;

`ifdef LED_PWM_EN
    logic [7:0] duty;
    logic [7:0] pwm_model;
    logic       gate_q;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] sel;
        logic [3:0] exp4;
        logic [2:0] exp3;
    } static_vec_t;

    typedef struct {
        logic [1:0] p4;
        logic [1:0] p3;
    } step_vec_t;

    static_vec_t svec[4];
    step_vec_t   chase_vec[6];
    step_vec_t   bounce_vec[7];

    always #5 clk = ~clk;

    led_pattern_ctrl #(.NUM_LEDS(4), .TICK_DIV(4)) dut4 (
        .clk(clk), .rst(rst),
`ifdef LED_PWM_EN
        .duty(duty),
`endif
        .en(en), .mode(mode), .sel(sel), .leds(leds4), .tick(tick4), .pos(pos4)
    );

    led_pattern_ctrl #(.NUM_LEDS(3), .TICK_DIV(4)) dut3 (
        .clk(clk), .rst(rst),
`ifdef LED_PWM_EN
        .duty(duty),
`endif
        .en(en), .mode(mode), .sel(sel), .leds(leds3), .tick(tick3), .pos(pos3)
    );

    led_pattern_ctrl #(.NUM_LEDS(1), .TICK_DIV(4)) dut1 (
        .clk(clk), .rst(rst),
`ifdef LED_PWM_EN
        .duty(duty),
`endif
        .en(en), .mode(mode), .sel(sel[0]), .leds(leds1), .tick(tick1), .pos(pos1)
    );

`ifdef LED_PWM_EN
    // Reference PWM gate: registered alongside the LEDs, from the counter value before the edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_model <= 8'd0;
            gate_q    <= 1'b0;
        end else begin
            gate_q <= en && (pwm_model < duty);
            if (en) pwm_model <= pwm_model + 8'd1;
        end
    end
`endif

    function automatic logic [3:0] gate(input logic [3:0] x);
`ifdef LED_PWM_EN
        return gate_q ? x : 4'b0000;
`else
        return x;
`endif
    endfunction

    task automatic stepClk();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic e, input logic [1:0] m, input logic [1:0] s);
        en   = e;
        mode = m;
        sel  = s;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        int found;
        int hits;

        svec[0] = '{sel: 2'd0, exp4: 4'b0001, exp3: 3'b001};
        svec[1] = '{sel: 2'd1, exp4: 4'b0010, exp3: 3'b010};
        svec[2] = '{sel: 2'd2, exp4: 4'b0100, exp3: 3'b100};
        svec[3] = '{sel: 2'd3, exp4: 4'b1000, exp3: 3'b000};

        chase_vec[0] = '{p4: 2'd1, p3: 2'd1};
        chase_vec[1] = '{p4: 2'd2, p3: 2'd2};
        chase_vec[2] = '{p4: 2'd3, p3: 2'd0};
        chase_vec[3] = '{p4: 2'd0, p3: 2'd1};
        chase_vec[4] = '{p4: 2'd1, p3: 2'd2};
        chase_vec[5] = '{p4: 2'd2, p3: 2'd0};

        bounce_vec[0] = '{p4: 2'd1, p3: 2'd1};
        bounce_vec[1] = '{p4: 2'd2, p3: 2'd2};
        bounce_vec[2] = '{p4: 2'd3, p3: 2'd1};
        bounce_vec[3] = '{p4: 2'd2, p3: 2'd0};
        bounce_vec[4] = '{p4: 2'd1, p3: 2'd1};
        bounce_vec[5] = '{p4: 2'd0, p3: 2'd2};
        bounce_vec[6] = '{p4: 2'd1, p3: 2'd1};

        rst = 1'b1;
`ifdef LED_PWM_EN
        duty = 8'd255;
`endif
        applyStimulus(1'b0, 2'b00, 2'd0);
        repeat (3) stepClk();
        checkOutput("reset_leds4", leds4, 0);
        checkOutput("reset_pos4", pos4, 0);
        checkOutput("reset_tick4", tick4, 0);
        checkOutput("reset_leds3", leds3, 0);
        checkOutput("reset_leds1", leds1, 0);

        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b00, svec[i].sel);
            stepClk();
            checkOutput("static_leds4", leds4, gate(svec[i].exp4));
            checkOutput("static_leds3", leds3, gate({1'b0, svec[i].exp3}));
            checkOutput("static_pos4", pos4, 0);
        end

        found = 0;
        for (int k = 0; k < 8 && found == 0; k++) begin
            stepClk();
            if (tick4) found = 1;
        end
        checkOutput("tick_found", found, 1);
        for (int k = 1; k <= 14; k++) begin
            stepClk();
            checkOutput("tick_period", tick4, (k % 4 == 0));
        end

        applyStimulus(1'b0, 2'b00, 2'd3);
        for (int k = 1; k <= 10; k++) begin
            stepClk();
            checkOutput("en_off_tick", tick4, 0);
            checkOutput("en_off_leds", leds4, 0);
        end
        applyStimulus(1'b1, 2'b00, 2'd3);
        for (int k = 1; k <= 4; k++) begin
            stepClk();
            checkOutput("en_resume_tick", tick4, (k == 2));
            checkOutput("en_resume_leds", leds4, gate(4'b1000));
        end

        applyStimulus(1'b1, 2'b01, 2'd2);
        for (int k = 1; k <= 16; k++) begin
            stepClk();
            checkOutput("blink_leds4", leds4, gate((((k - 1) / 4) % 2 == 0) ? 4'b0100 : 4'b0000));
            checkOutput("blink_leds3", leds3, gate((((k - 1) / 4) % 2 == 0) ? 4'b0100 : 4'b0000));
            checkOutput("blink_tick", tick4, (k > 1 && (k - 1) % 4 == 0));
            checkOutput("blink_pos", pos4, 0);
        end

        applyStimulus(1'b1, 2'b10, 2'd0);
        stepClk();
        checkOutput("chase_entry_pos", pos4, 0);
        checkOutput("chase_entry_tick", tick4, 0);
        checkOutput("chase_entry_leds", leds4, gate(4'b0001));
        for (int t = 0; t < 6; t++) begin
            repeat (3) stepClk();
            stepClk();
            checkOutput("chase_tick", tick4, 1);
            checkOutput("chase_pos4", pos4, chase_vec[t].p4);
            checkOutput("chase_leds4", leds4, gate(4'b0001 << chase_vec[t].p4));
            checkOutput("chase_pos3", pos3, chase_vec[t].p3);
            checkOutput("chase_leds3", leds3, gate(4'b0001 << chase_vec[t].p3));
            checkOutput("chase_tick3", tick3, 1);
            checkOutput("chase_pos1", pos1, 0);
            checkOutput("chase_leds1", leds1, gate(4'b0001));
        end

        applyStimulus(1'b1, 2'b11, 2'd0);
        stepClk();
        checkOutput("bounce_entry_pos4", pos4, 0);
        checkOutput("bounce_entry_pos3", pos3, 0);
        checkOutput("bounce_entry_tick", tick4, 0);
        for (int t = 0; t < 7; t++) begin
            repeat (3) stepClk();
            stepClk();
            checkOutput("bounce_tick", tick4, 1);
            checkOutput("bounce_pos4", pos4, bounce_vec[t].p4);
            checkOutput("bounce_leds4", leds4, gate(4'b0001 << bounce_vec[t].p4));
            checkOutput("bounce_pos3", pos3, bounce_vec[t].p3);
            checkOutput("bounce_tick1", tick1, 1);
            checkOutput("bounce_pos1", pos1, 0);
            checkOutput("bounce_leds1", leds1, gate(4'b0001));
        end

        repeat (3) stepClk();
        applyStimulus(1'b1, 2'b10, 2'd0);
        stepClk();
        checkOutput("modechg_tick", tick4, 0);
        checkOutput("modechg_pos4", pos4, 0);
        checkOutput("modechg_pos3", pos3, 0);
        checkOutput("modechg_leds4", leds4, gate(4'b0001));
        repeat (3) stepClk();
        stepClk();
        checkOutput("modechg_next_tick", tick4, 1);
        checkOutput("modechg_next_pos", pos4, 1);

        applyStimulus(1'b1, 2'b11, 2'd0);
        stepClk();
        repeat (8) stepClk();
        checkOutput("prerst_pos4", pos4, 2);
        checkOutput("prerst_leds4", leds4, gate(4'b0100));
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_leds4", leds4, 0);
        checkOutput("async_rst_pos4", pos4, 0);
        checkOutput("async_rst_pos3", pos3, 0);
        checkOutput("async_rst_tick4", tick4, 0);
        stepClk();
        rst = 1'b0;
        stepClk();
        checkOutput("post_rst_pos", pos4, 0);
        checkOutput("post_rst_leds", leds4, gate(4'b0001));
        repeat (3) stepClk();
        stepClk();
        checkOutput("post_rst_tick", tick4, 1);
        checkOutput("post_rst_step", pos4, 1);

`ifdef LED_PWM_EN
        applyStimulus(1'b1, 2'b00, 2'd0);
        duty = 8'd64;
        repeat (2) stepClk();
        hits = 0;
        for (int k = 0; k < 256; k++) begin
            stepClk();
            if (leds4[0]) hits++;
        end
        checkOutput("pwm_duty64", hits, 64);
        duty = 8'd0;
        stepClk();
        hits = 0;
        for (int k = 0; k < 256; k++) begin
            stepClk();
            if (leds4[0]) hits++;
        end
        checkOutput("pwm_duty0", hits, 0);
`else
        hits = 0;
        found = hits;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
Parametrised successor to the 3-LED select decoder. Drives NUM_LEDS outputs from a select input and adds timed modes: static, blink, chase and bounce. All modes share one prescaler-generated step tick. Sits between board-level switch/config inputs and the LED pins; all outputs are registered.

Parameters:
NUM_LEDS, 8, number of LED outputs (>=1)
TICK_DIV, 4, clk cycles per step tick (>=2)
SEL_W, $clog2(NUM_LEDS) (min 1), width of sel and pos; localparam, derived

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  run enable
mode  input  2  00 STATIC, 01 BLINK, 10 CHASE, 11 BOUNCE
sel  input  SEL_W  selected LED index (STATIC/BLINK)
leds  output  NUM_LEDS  LED drive, bit i = LED i, 1 = on
tick  output  1  one-cycle pulse per prescaler wrap
pos  output  SEL_W  current CHASE/BOUNCE position

Behaviour:
- Reset (async, rst=1): leds=0, tick=0, pos=0, cnt=0, dir=UP, phase=ON, mode_q=00.
- Prescaler: cnt (width clog2(TICK_DIV)) increments each clk while en=1. At cnt==TICK_DIV-1 it wraps to 0 and tick=1 on the next cycle (registered), so one tick every TICK_DIV cycles.
- en=0: cnt, pos, dir and phase hold; tick=0; leds=0 from the next cycle. Re-asserting en resumes from the held state.
- Mode change: mode_q registers mode. In any cycle with mode!=mode_q: cnt=0, pos=0, dir=UP, phase=ON, no tick that cycle. Mode-change clearing takes priority over a coincident tick.
- All leds updates are registered, so leds reflects inputs and state with 1-cycle latency.
- STATIC: leds = one-hot(sel). If sel>=NUM_LEDS, leds=0. sel changes take effect on the next cycle; timing state is unaffected.
- BLINK: phase toggles on each tick. leds = one-hot(sel) when phase=ON, else 0. Out-of-range sel gives 0.
- CHASE: on each tick, pos = (pos==NUM_LEDS-1) ? 0 : pos+1. leds = one-hot(pos).
- BOUNCE: on each tick, if dir=UP: pos+1, and dir flips to DOWN when the new pos reaches NUM_LEDS-1. If dir=DOWN: pos-1, and dir flips to UP when the new pos reaches 0. There is no dwell at the ends: for N=4 the sequence is 0,1,2,3,2,1,0,1. leds = one-hot(pos).
- NUM_LEDS=1: CHASE and BOUNCE hold pos=0 with leds=1.
- pos stays at 0 in STATIC and BLINK.
- Reset asserted mid-operation returns all state to reset values immediately. After release, operation restarts from pos=0 and phase=ON.

Optional Feature:
LED_PWM_EN: when defined, adds input port duty [7:0] and an 8-bit free-running pwm_cnt (runs while en=1; reset 0). The final output is leds = pattern & {NUM_LEDS{pwm_cnt < duty}}. duty=0 gives always off; duty=255 gives on for 255 of every 256 cycles. Pattern state (pos, phase, tick) is unaffected by PWM. When undefined: no duty port, no pwm_cnt, and leds = pattern directly.

Test Plan:
- Reset/STATIC (NUM_LEDS=4, TICK_DIV=4): hold rst for 3 cycles -> leds=0000, pos=0. Release, en=1, mode=00, sweep sel 0..3 -> leds 0001, 0010, 0100, 1000, each 1 cycle after the sel change. sel=3 with NUM_LEDS=3 -> leds=000.
- Tick: en=1 -> tick pulses exactly every 4 cycles. Drop en for 10 cycles -> no tick, leds=0. Raise en -> ticks resume with the held cnt phase.
- BLINK: mode=01, sel=2 -> leds alternates 0100/0000 every 4 cycles, starting with ON.
- CHASE/BOUNCE: mode=10 for 6 ticks -> pos 1,2,3,0,1,2. Switch to mode=11 -> pos cleared to 0, then 1,2,3,2,1,0,1 on successive ticks.
- Mid-op events: mode change on the same cycle as a tick -> pos=0 and no step. Assert rst asynchronously between clock edges during BOUNCE at pos=2 -> leds=0 and pos=0 immediately.
- LED_PWM_EN build: mode=00, sel=0, duty=64 -> leds[0] high for exactly 64 of every 256 cycles. duty=0 -> never high. Non-macro build compiles without a duty port.
